mem_bus_arbiter: RTL and testbench

- Shares the single B322 memory bus between two bus masters.
  - Master 0 is the CPU.
  - Master 1 is a secondary requester, e.g. a DMA or GPU copy engine.
- The memory bus is the address/data/we/start/q/busy handshake.
- Each master sees a private copy of that handshake. The arbiter latches pulsed requests, grants in round-robin (or fixed) order, and forwards exactly one transaction at a time to memory.
- It sits between the CPU/secondary master and the memory unit (SDRAM/SPI/IO mux).

---
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the B322 memory bus. Each master's pulsed request is latched,
// granted round-robin or fixed-priority, and forwarded to memory one transaction at a time.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m0_we,
  input  logic              m0_start,
  output logic [DATA_W-1:0] m0_q,
  output logic              m0_busy,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_data,
  input  logic              m1_we,
  input  logic              m1_start,
  output logic [DATA_W-1:0] m1_q,
  output logic              m1_busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_start,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic fixed_prio_c = (FIXED_PRIO != 32'sd0);

  state_t              state_r, state_s;
  logic                issue_s, done_s, sel_s;
  logic                grant_r, last_grant_r;
  logic                pend0_r, pend1_r;
  logic [ADDR_W-1:0]   m0_addr_r, m1_addr_r, mem_address_r;
  logic [DATA_W-1:0]   m0_data_r, m1_data_r, mem_data_r;
  logic                m0_we_r, m1_we_r, mem_we_r, mem_start_r;
  logic [DATA_W-1:0]   m0_q_r, m1_q_r;

  assign m0_busy     = pend0_r;
  assign m1_busy     = pend1_r;
  assign m0_q        = m0_q_r;
  assign m1_q        = m1_q_r;
  assign mem_address = mem_address_r;
  assign mem_data    = mem_data_r;
  assign mem_we      = mem_we_r;
  assign mem_start   = mem_start_r;

  // Arbiter state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic and grant selection; a tie goes to the master not served last
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    done_s  = 1'b0;
    sel_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend0_r || pend1_r) begin
          issue_s = 1'b1;
          state_s = ISSUE;
          if (pend0_r && pend1_r) sel_s = fixed_prio_c ? 1'b0 : ~last_grant_r;
          else                    sel_s = pend1_r;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE:    state_s = WAIT_ACK;
      WAIT_ACK: begin
        if (mem_busy) state_s = WAIT_DONE;
        else          state_s = WAIT_ACK;
      end
      WAIT_DONE: begin
        if (!mem_busy) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Master 0 request capture; busy doubles as the pending flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend0_r   <= 1'b0;
      m0_addr_r <= {ADDR_W{1'b0}};
      m0_data_r <= {DATA_W{1'b0}};
      m0_we_r   <= 1'b0;
    end else if (!pend0_r && m0_start) begin
      pend0_r   <= 1'b1;
      m0_addr_r <= m0_address;
      m0_data_r <= m0_data;
      m0_we_r   <= m0_we;
    end else if (done_s && !grant_r) begin
      pend0_r   <= 1'b0;
    end
  end

  // Master 1 request capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend1_r   <= 1'b0;
      m1_addr_r <= {ADDR_W{1'b0}};
      m1_data_r <= {DATA_W{1'b0}};
      m1_we_r   <= 1'b0;
    end else if (!pend1_r && m1_start) begin
      pend1_r   <= 1'b1;
      m1_addr_r <= m1_address;
      m1_data_r <= m1_data;
      m1_we_r   <= m1_we;
    end else if (done_s && grant_r) begin
      pend1_r   <= 1'b0;
    end
  end

  // Memory-side issue, grant history and read-data return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_start_r   <= 1'b0;
      mem_address_r <= {ADDR_W{1'b0}};
      mem_data_r    <= {DATA_W{1'b0}};
      mem_we_r      <= 1'b0;
      grant_r       <= 1'b0;
      last_grant_r  <= 1'b1;
      m0_q_r        <= {DATA_W{1'b0}};
      m1_q_r        <= {DATA_W{1'b0}};
    end else begin
      mem_start_r <= issue_s;
      if (issue_s) begin
        grant_r       <= sel_s;
        mem_address_r <= sel_s ? m1_addr_r : m0_addr_r;
        mem_data_r    <= sel_s ? m1_data_r : m0_data_r;
        mem_we_r      <= sel_s ? m1_we_r   : m0_we_r;
      end
      if (done_s) begin
        last_grant_r <= grant_r;
        if (grant_r) m1_q_r <= mem_q;
        else         m0_q_r <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin and a fixed-priority instance share
// the master stimulus, each with its own latency-programmable memory model.
module tb_mem_bus_arbiter;
  localparam int AW = 27;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [DW-1:0] m0_data = '0, m1_data = '0;
  logic          m0_we = 1'b0, m1_we = 1'b0, m0_start = 1'b0, m1_start = 1'b0;

  logic [DW-1:0] m0_q, m1_q, mem_data, mem_q;
  logic          m0_busy, m1_busy, mem_we, mem_start, mem_busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] f_m0_q, f_m1_q, f_mem_data, f_mem_q;
  logic          f_m0_busy, f_m1_busy, f_mem_we, f_mem_start, f_mem_busy;
  logic [AW-1:0] f_mem_address;

  int lat = 1;
  int checks = 0;
  int errors = 0;
  int cnt_rr, cnt_fp;
  int starts_rr = 0;
  logic [AW-1:0] log_rr[$];
  logic [AW-1:0] log_fp[$];

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_data(m0_data), .m0_we(m0_we), .m0_start(m0_start),
    .m0_q(m0_q), .m0_busy(m0_busy),
    .m1_address(m1_address), .m1_data(m1_data), .m1_we(m1_we), .m1_start(m1_start),
    .m1_q(m1_q), .m1_busy(m1_busy),
    .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we), .mem_start(mem_start),
    .mem_q(mem_q), .mem_busy(mem_busy));

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_data(m0_data), .m0_we(m0_we), .m0_start(m0_start),
    .m0_q(f_m0_q), .m0_busy(f_m0_busy),
    .m1_address(m1_address), .m1_data(m1_data), .m1_we(m1_we), .m1_start(m1_start),
    .m1_q(f_m1_q), .m1_busy(f_m1_busy),
    .mem_address(f_mem_address), .mem_data(f_mem_data), .mem_we(f_mem_we), .mem_start(f_mem_start),
    .mem_q(f_mem_q), .mem_busy(f_mem_busy));

  // Memory for the round-robin instance: busy for 'lat' cycles after each start
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_busy <= 1'b0;
      cnt_rr   <= 0;
    end else if (mem_busy) begin
      if (cnt_rr <= 1) mem_busy <= 1'b0;
      cnt_rr <= cnt_rr - 1;
    end else if (mem_start) begin
      mem_busy <= 1'b1;
      cnt_rr   <= lat;
      mem_q    <= (mem_address == 27'h0000123) ? 32'hDEADBEEF : (32'h5A5A0000 ^ {5'd0, mem_address});
    end
  end

  // Issue log and pulse count for the round-robin instance
  always @(posedge clk) begin
    if (mem_start) begin
      starts_rr <= starts_rr + 1;
      log_rr.push_back(mem_address);
    end
  end

  // Memory for the fixed-priority instance
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_mem_busy <= 1'b0;
      cnt_fp     <= 0;
    end else if (f_mem_busy) begin
      if (cnt_fp <= 1) f_mem_busy <= 1'b0;
      cnt_fp <= cnt_fp - 1;
    end else if (f_mem_start) begin
      f_mem_busy <= 1'b1;
      cnt_fp     <= lat;
      f_mem_q    <= 32'h5A5A0000 ^ {5'd0, f_mem_address};
      log_fp.push_back(f_mem_address);
    end
  end

  task automatic req(input logic s0, input logic s1, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d, input logic we);
    m0_address = a0; m1_address = a1; m0_data = d; m1_data = d;
    m0_we = we; m1_we = we; m0_start = s0; m1_start = s1;
    @(negedge clk);
    m0_start = 1'b0; m1_start = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 300; i++) begin
      if (!m0_busy && !m1_busy && !f_m0_busy && !f_m1_busy) break;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m0_start = 1'b0; m1_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_address = '0; m1_address = '0; m0_data = '0; m1_data = '0;
    m0_we = 1'b0; m1_we = 1'b0; m0_start = 1'b0; m1_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_start, mem_we, m0_busy, m1_busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl got %b exp 0000", {mem_start, mem_we, m0_busy, m1_busy});
    end
    checks++;
    if (mem_address !== 27'h0 || mem_data !== 32'h0) begin
      errors++; $display("FAIL reset_bus got addr %h data %h exp 0 0", mem_address, mem_data);
    end
    checks++;
    if (m0_q !== 32'h0 || m1_q !== 32'h0) begin
      errors++; $display("FAIL reset_q got %h %h exp 0 0", m0_q, m1_q);
    end
    checks++;
    if ({f_mem_start, f_mem_we, f_m0_busy, f_m1_busy} !== 4'b0000 || f_mem_address !== 27'h0 ||
        f_mem_data !== 32'h0 || f_m0_q !== 32'h0 || f_m1_q !== 32'h0) begin
      errors++; $display("FAIL reset_fp got start %b busy %b%b addr %h exp all 0", f_mem_start, f_m0_busy, f_m1_busy, f_mem_address);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_read();
    int b;
    lat = 1;
    b = starts_rr;
    req(1'b1, 1'b0, 27'h0000123, 27'h0, 32'h0, 1'b0);
    checks++;
    if (m0_busy !== 1'b1 || mem_start !== 1'b0) begin
      errors++; $display("FAIL basic_accept got busy %b start %b exp 1 0", m0_busy, mem_start);
    end
    @(negedge clk);
    checks++;
    if (mem_start !== 1'b1 || mem_address !== 27'h0000123 || mem_we !== 1'b0) begin
      errors++; $display("FAIL basic_issue got start %b addr %h we %b exp 1 0000123 0", mem_start, mem_address, mem_we);
    end
    @(negedge clk);
    checks++;
    if (mem_start !== 1'b0) begin
      errors++; $display("FAIL basic_pulse got %b exp 0", mem_start);
    end
    @(negedge clk);
    checks++;
    if (m0_busy !== 1'b1) begin
      errors++; $display("FAIL basic_early got busy %b exp 1", m0_busy);
    end
    @(negedge clk);
    checks++;
    if (m0_busy !== 1'b0 || m0_q !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_done got busy %b q %h exp 0 deadbeef", m0_busy, m0_q);
    end
    checks++;
    if (m1_busy !== 1'b0 || m1_q !== 32'h0 || starts_rr - b !== 1) begin
      errors++; $display("FAIL basic_other got m1_busy %b m1_q %h starts %0d exp 0 0 1", m1_busy, m1_q, starts_rr - b);
    end
    settle();
  endtask

  task automatic test_round_robin();
    int b;
    do_reset();
    lat = 1;
    b = log_rr.size();
    req(1'b1, 1'b1, 27'h10, 27'h20, 32'h0, 1'b0);
    settle();
    checks++;
    if (m0_busy !== 1'b0 || m1_busy !== 1'b0 || log_rr.size() !== b + 2) begin
      errors++; $display("FAIL rr_first_done got busy %b%b issues %0d exp 00 2", m0_busy, m1_busy, log_rr.size() - b);
    end
    checks++;
    if (log_rr[b] !== 27'h10 || log_rr[b+1] !== 27'h20) begin
      errors++; $display("FAIL rr_first_order got %h %h exp 10 20", log_rr[b], log_rr[b+1]);
    end
    checks++;
    if (m0_q !== 32'h5A5A0010 || m1_q !== 32'h5A5A0020) begin
      errors++; $display("FAIL rr_first_q got %h %h exp 5a5a0010 5a5a0020", m0_q, m1_q);
    end
    req(1'b1, 1'b0, 27'h30, 27'h0, 32'h0, 1'b0);
    settle();
    req(1'b1, 1'b1, 27'h40, 27'h50, 32'h0, 1'b0);
    settle();
    checks++;
    if (log_rr.size() !== b + 5 || log_rr[b+3] !== 27'h50 || log_rr[b+4] !== 27'h40) begin
      errors++; $display("FAIL rr_alternate got %h %h exp 50 40", log_rr[b+3], log_rr[b+4]);
    end
  endtask

  task automatic test_fixed_prio();
    int brr, bfp;
    do_reset();
    lat = 2;
    brr = log_rr.size();
    bfp = log_fp.size();
    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] base;
      base = 27'h100 + 27'(k * 16);
      req(1'b1, 1'b0, base, 27'h0, 32'h0, 1'b0);
      settle();
      req(1'b1, 1'b1, base + 27'h1, base + 27'h2, 32'h0, 1'b0);
      settle();
      checks++;
      if (log_fp[bfp+3*k] !== base || log_fp[bfp+3*k+1] !== base + 27'h1 || log_fp[bfp+3*k+2] !== base + 27'h2) begin
        errors++; $display("FAIL fp_order k=%0d got %h %h %h exp %h %h %h", k, log_fp[bfp+3*k], log_fp[bfp+3*k+1],
                           log_fp[bfp+3*k+2], base, base + 27'h1, base + 27'h2);
      end
      checks++;
      if (log_rr[brr+3*k+1] !== base + 27'h2 || log_rr[brr+3*k+2] !== base + 27'h1) begin
        errors++; $display("FAIL rr_contest k=%0d got %h %h exp %h %h", k, log_rr[brr+3*k+1], log_rr[brr+3*k+2],
                           base + 27'h2, base + 27'h1);
      end
    end
  endtask

  task automatic test_long_write();
    int b;
    logic busy_ok;
    lat = 20;
    b = starts_rr;
    busy_ok = 1'b1;
    req(1'b0, 1'b1, 27'h0, 27'h7FFFFFF, 32'h12345678, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_start !== 1'b1 || mem_address !== 27'h7FFFFFF || mem_data !== 32'h12345678 || mem_we !== 1'b1) begin
      errors++; $display("FAIL write_issue got start %b addr %h data %h we %b exp 1 7ffffff 12345678 1",
                         mem_start, mem_address, mem_data, mem_we);
    end
    for (int i = 0; i < 18; i++) begin
      m1_start = (i == 5);
      m1_address = 27'h0001111;
      @(negedge clk);
      if (m1_busy !== 1'b1) busy_ok = 1'b0;
    end
    m1_start = 1'b0;
    checks++;
    if (busy_ok !== 1'b1) begin
      errors++; $display("FAIL write_busy got a low m1_busy exp 1 throughout");
    end
    settle();
    checks++;
    if (m1_busy !== 1'b0 || starts_rr - b !== 1 || mem_address !== 27'h7FFFFFF) begin
      errors++; $display("FAIL write_single got busy %b starts %0d addr %h exp 0 1 7ffffff", m1_busy, starts_rr - b, mem_address);
    end
  endtask

  task automatic test_wait_done();
    lat = 4;
    req(1'b0, 1'b1, 27'h0, 27'h66, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    req(1'b1, 1'b0, 27'h77, 27'h66, 32'h0, 1'b0);
    for (int i = 0; i < 50 && m1_busy; i++) @(negedge clk);
    checks++;
    if (m1_busy !== 1'b0 || mem_start !== 1'b0 || m0_busy !== 1'b1) begin
      errors++; $display("FAIL wd_idle got m1_busy %b start %b m0_busy %b exp 0 0 1", m1_busy, mem_start, m0_busy);
    end
    @(negedge clk);
    checks++;
    if (mem_start !== 1'b1 || mem_address !== 27'h77) begin
      errors++; $display("FAIL wd_issue got start %b addr %h exp 1 77", mem_start, mem_address);
    end
    settle();
    checks++;
    if (m0_q !== 32'h5A5A0077 || m1_q !== 32'h5A5A0066 || m0_busy !== 1'b0) begin
      errors++; $display("FAIL wd_q got %h %h busy %b exp 5a5a0077 5a5a0066 0", m0_q, m1_q, m0_busy);
    end
  endtask

  task automatic test_reset_mid();
    lat = 20;
    req(1'b1, 1'b0, 27'h99, 27'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (mem_start !== 1'b0 || m0_busy !== 1'b0) begin
      errors++; $display("FAIL rst_issue got start %b busy %b exp 0 0", mem_start, m0_busy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req(1'b1, 1'b1, 27'hAB, 27'hCD, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({mem_start, m0_busy, m1_busy} !== 3'b000) begin
      errors++; $display("FAIL rst_wait_done got %b exp 000", {mem_start, m0_busy, m1_busy});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    lat = 1;
    req(1'b1, 1'b0, 27'hAA, 27'h0, 32'h0, 1'b0);
    settle();
    checks++;
    if (m0_busy !== 1'b0 || m1_busy !== 1'b0 || m0_q !== 32'h5A5A00AA || log_rr[log_rr.size()-1] !== 27'hAA) begin
      errors++; $display("FAIL rst_recover got busy %b%b q %h last %h exp 00 5a5a00aa aa",
                         m0_busy, m1_busy, m0_q, log_rr[log_rr.size()-1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_round_robin();
    test_fixed_prio();
    test_long_write();
    test_wait_done();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
